// File: rtl/ulpb_rx_dispatch_pkg.sv
// Shared definitions for the ulpb RX dispatcher: default bus widths, FSM state
// encoding and the control FIFO entry layout {idx[1:0], data}.
package ulpb_rx_dispatch_pkg;

  localparam int ULPB_ADDR_W = 8;
  localparam int ULPB_DATA_W = 32;
  localparam int CTRL_IDX_W  = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CAP      = 3'd1,
    ST_FWD_REQ  = 3'd2,
    ST_FWD_DONE = 3'd3,
    ST_ACK_WAIT = 3'd4
  } rx_state_e;

  // Width of one control FIFO entry: match index above the data word.
  function automatic int ctrl_entry_w(input int data_w);
    return data_w + CTRL_IDX_W;
  endfunction

endpackage

// File: rtl/ulpb_rx_dispatch_if.sv
// Bundle of the node RX handshake, the layer handshake and the control FIFO
// read side. The dispatcher uses the slave view; its environment the master view.
interface ulpb_rx_dispatch_if #(
  parameter int ADDR_WIDTH = ulpb_rx_dispatch_pkg::ULPB_ADDR_W,
  parameter int DATA_WIDTH = ulpb_rx_dispatch_pkg::ULPB_DATA_W
);
  logic [ADDR_WIDTH-1:0] NODE_RX_ADDR;
  logic [DATA_WIDTH-1:0] NODE_RX_DATA;
  logic                  NODE_RX_PEND;
  logic                  NODE_RX_REQ;
  logic                  NODE_RX_ACK;
  logic [ADDR_WIDTH-1:0] RX_ADDR;
  logic [DATA_WIDTH-1:0] RX_DATA;
  logic                  RX_PEND;
  logic                  RX_REQ;
  logic                  RX_ACK;
  logic                  CTRL_RD_EN;
  logic                  CTRL_EMPTY;
  logic                  CTRL_FULL;
  logic [DATA_WIDTH-1:0] CTRL_DATA;
  logic [1:0]            CTRL_IDX;
  logic [7:0]            CTRL_DROP_CNT;

  modport slave (
    input  NODE_RX_ADDR, NODE_RX_DATA, NODE_RX_PEND, NODE_RX_REQ, RX_ACK, CTRL_RD_EN,
    output NODE_RX_ACK, RX_ADDR, RX_DATA, RX_PEND, RX_REQ,
           CTRL_EMPTY, CTRL_FULL, CTRL_DATA, CTRL_IDX, CTRL_DROP_CNT
  );

  modport master (
    output NODE_RX_ADDR, NODE_RX_DATA, NODE_RX_PEND, NODE_RX_REQ, RX_ACK, CTRL_RD_EN,
    input  NODE_RX_ACK, RX_ADDR, RX_DATA, RX_PEND, RX_REQ,
           CTRL_EMPTY, CTRL_FULL, CTRL_DATA, CTRL_IDX, CTRL_DROP_CNT
  );
endinterface

// File: rtl/ulpb_rx_dispatch_fifo.sv
// ulpb_sync_fifo: single-clock first-word fall-through FIFO. Pointers carry one
// extra wrap bit so full/empty come straight from a pointer compare. A push into
// a full FIFO is refused even when a pop happens in the same cycle.
module ulpb_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic             w_wr, w_rd;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr      = i_wr_en & ~o_full;
  assign w_rd      = i_rd_en & ~o_empty;
  // Head shows zero while empty so the output is defined out of reset.
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Storage array, written on accepted pushes only.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  // Pointer update; reset flushes the FIFO.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_rd) r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end
endmodule

// File: rtl/ulpb_rx_dispatch.sv
// ulpb RX dispatcher. Messages whose address matches a control address/mask pair
// are auto-acked and queued in the control FIFO; everything else is forwarded to
// the layer over a four-phase REQ/ACK handshake.
// Optional: define ULPB_RX_DISPATCH_DROP_EN to discard (and count) control
// messages that arrive while the FIFO is full instead of stalling the node.
module ulpb_rx_dispatch
  import ulpb_rx_dispatch_pkg::*;
#(
  parameter int ADDR_WIDTH    = ULPB_ADDR_W,
  parameter int DATA_WIDTH    = ULPB_DATA_W,
  parameter int NUM_CTRL_ADDR = 2,
  parameter logic [NUM_CTRL_ADDR*ADDR_WIDTH-1:0] CTRL_ADDRESS   = {8'h01, 8'h00},
  parameter logic [NUM_CTRL_ADDR*ADDR_WIDTH-1:0] CTRL_ADDR_MASK = {8'hff, 8'hff},
  parameter int FIFO_DEPTH    = 4
) (
  input  logic              i_CLK_EXT,
  input  logic              i_RESET,
  ulpb_rx_dispatch_if.slave bus
);
  localparam int EW = ctrl_entry_w(DATA_WIDTH);

  logic            r_req_meta, r_req_s;
  logic            w_match;
  logic [1:0]      w_idx, r_idx;
  rx_state_e       r_state, w_state_nxt;
  logic            r_node_ack, w_node_ack_nxt;
  logic            r_rx_req, w_rx_req_nxt;
  logic            w_push, w_load_fwd, w_load_idx;
  logic            w_fifo_full, w_fifo_empty;
  logic [EW-1:0]   w_fifo_rd;
  logic [ADDR_WIDTH-1:0] r_rx_addr;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_pend;
`ifdef ULPB_RX_DISPATCH_DROP_EN
  logic            w_drop;
  logic [7:0]      r_drop_cnt;
`endif

  // Two-flop synchroniser for the node request.
  always_ff @(posedge i_CLK_EXT) begin
    if (i_RESET) begin
      r_req_meta <= 1'b0;
      r_req_s    <= 1'b0;
    end else begin
      r_req_meta <= bus.NODE_RX_REQ;
      r_req_s    <= r_req_meta;
    end
  end

  // Address classification; scan high to low so the lowest matching pair wins.
  always_comb begin
    w_match = 1'b0;
    w_idx   = 2'd0;
    for (int i = NUM_CTRL_ADDR-1; i >= 0; i--) begin
      if (((bus.NODE_RX_ADDR ^ CTRL_ADDRESS[i*ADDR_WIDTH +: ADDR_WIDTH])
           & CTRL_ADDR_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == '0) begin
        w_match = 1'b1;
        w_idx   = 2'(i);
      end
    end
  end

  // Next-state and handshake decisions.
  always_comb begin
    w_state_nxt    = r_state;
    w_node_ack_nxt = r_node_ack;
    w_rx_req_nxt   = r_rx_req;
    w_push         = 1'b0;
    w_load_fwd     = 1'b0;
    w_load_idx     = 1'b0;
`ifdef ULPB_RX_DISPATCH_DROP_EN
    w_drop         = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (r_req_s) begin
          if (w_match) begin
            w_load_idx  = 1'b1;
            w_state_nxt = ST_CAP;
          end else begin
            w_load_fwd   = 1'b1;
            w_rx_req_nxt = 1'b1;
            w_state_nxt  = ST_FWD_REQ;
          end
        end
      end
      ST_CAP: begin
        if (!w_fifo_full) begin
          w_push         = 1'b1;
          w_node_ack_nxt = 1'b1;
          w_state_nxt    = ST_ACK_WAIT;
        end else begin
`ifdef ULPB_RX_DISPATCH_DROP_EN
          w_drop         = 1'b1;
          w_node_ack_nxt = 1'b1;
          w_state_nxt    = ST_ACK_WAIT;
`else
          w_state_nxt    = ST_CAP;
`endif
        end
      end
      ST_FWD_REQ: begin
        if (bus.RX_ACK) begin
          w_rx_req_nxt   = 1'b0;
          w_node_ack_nxt = 1'b1;
          w_state_nxt    = ST_FWD_DONE;
        end
      end
      ST_FWD_DONE: begin
        if (!r_req_s && !bus.RX_ACK) begin
          w_node_ack_nxt = 1'b0;
          w_state_nxt    = ST_IDLE;
        end
      end
      ST_ACK_WAIT: begin
        if (!r_req_s) begin
          w_node_ack_nxt = 1'b0;
          w_state_nxt    = ST_IDLE;
        end
      end
      default: begin
        w_node_ack_nxt = 1'b0;
        w_rx_req_nxt   = 1'b0;
        w_state_nxt    = ST_IDLE;
      end
    endcase
  end

  // State and handshake registers; reset abandons any transaction in flight.
  always_ff @(posedge i_CLK_EXT) begin
    if (i_RESET) begin
      r_state    <= ST_IDLE;
      r_node_ack <= 1'b0;
      r_rx_req   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_node_ack <= w_node_ack_nxt;
      r_rx_req   <= w_rx_req_nxt;
    end
  end

  // Layer-side message registers and the captured match index.
  always_ff @(posedge i_CLK_EXT) begin
    if (i_RESET) begin
      r_rx_addr <= '0;
      r_rx_data <= '0;
      r_rx_pend <= 1'b0;
      r_idx     <= 2'd0;
    end else begin
      if (w_load_fwd) begin
        r_rx_addr <= bus.NODE_RX_ADDR;
        r_rx_data <= bus.NODE_RX_DATA;
        r_rx_pend <= bus.NODE_RX_PEND;
      end
      if (w_load_idx) r_idx <= w_idx;
    end
  end

`ifdef ULPB_RX_DISPATCH_DROP_EN
  // Saturating count of control messages discarded on a full FIFO.
  always_ff @(posedge i_CLK_EXT) begin
    if (i_RESET)                          r_drop_cnt <= 8'd0;
    else if (w_drop && r_drop_cnt != 8'hff) r_drop_cnt <= r_drop_cnt + 8'd1;
  end
  assign bus.CTRL_DROP_CNT = r_drop_cnt;
`else
  assign bus.CTRL_DROP_CNT = 8'd0;
`endif

  ulpb_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_ctrl_fifo (
    .i_clk     (i_CLK_EXT),
    .i_rst     (i_RESET),
    .i_wr_en   (w_push),
    .i_wr_data ({r_idx, bus.NODE_RX_DATA}),
    .i_rd_en   (bus.CTRL_RD_EN),
    .o_rd_data (w_fifo_rd),
    .o_empty   (w_fifo_empty),
    .o_full    (w_fifo_full)
  );

  assign bus.NODE_RX_ACK = r_node_ack;
  assign bus.RX_REQ      = r_rx_req;
  assign bus.RX_ADDR     = r_rx_addr;
  assign bus.RX_DATA     = r_rx_data;
  assign bus.RX_PEND     = r_rx_pend;
  assign bus.CTRL_EMPTY  = w_fifo_empty;
  assign bus.CTRL_FULL   = w_fifo_full;
  assign bus.CTRL_DATA   = w_fifo_rd[DATA_WIDTH-1:0];
  assign bus.CTRL_IDX    = w_fifo_rd[DATA_WIDTH +: CTRL_IDX_W];
endmodule

// File: tb/tb_ulpb_rx_dispatch.sv
// Directed bench for ulpb_rx_dispatch: a vector table of single messages plus
// hand-written sequences for FIFO full (stall or drop), priority and reset.
module tb_ulpb_rx_dispatch;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  // Pair 0 = 8'h01, pair 1 = 8'h00, both fully compared.
  ulpb_rx_dispatch_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();
  // Overlapping pairs: pair 0 = 8'h1x (mask f0), pair 1 = 8'h12 exact.
  ulpb_rx_dispatch_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus2 ();

  ulpb_rx_dispatch #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_CTRL_ADDR(2),
    .CTRL_ADDRESS({8'h00, 8'h01}), .CTRL_ADDR_MASK({8'hff, 8'hff}), .FIFO_DEPTH(4)
  ) dut (.i_CLK_EXT(clk), .i_RESET(rst), .bus(bus));

  ulpb_rx_dispatch #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_CTRL_ADDR(2),
    .CTRL_ADDRESS({8'h12, 8'h10}), .CTRL_ADDR_MASK({8'hff, 8'hf0}), .FIFO_DEPTH(4)
  ) dut2 (.i_CLK_EXT(clk), .i_RESET(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic        pend;
    logic        is_ctrl;
    logic [1:0]  idx;
  } vec_t;
  vec_t vecs[5];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else n_pass++;
  endtask

  // Control message: acked on the 4th edge, REQ dropped, ack released 3 edges later.
  task automatic ctrl_send(input logic [7:0] a, input logic [31:0] d);
    bus.NODE_RX_ADDR = a;
    bus.NODE_RX_DATA = d;
    bus.NODE_RX_REQ  = 1'b1;
    step(3);
    chk("ctrl_ack_early", bus.NODE_RX_ACK, 0);
    step(1);
    chk("ctrl_ack", bus.NODE_RX_ACK, 1);
    chk("ctrl_no_rxreq", bus.RX_REQ, 0);
    chk("ctrl_nonempty", bus.CTRL_EMPTY, 0);
    bus.NODE_RX_REQ = 1'b0;
    step(2);
    chk("ctrl_ack_hold", bus.NODE_RX_ACK, 1);
    step(1);
    chk("ctrl_ack_rel", bus.NODE_RX_ACK, 0);
  endtask

  // Forwarded message: full four-phase handshake with the layer.
  task automatic fwd_send(input logic [7:0] a, input logic [31:0] d, input logic p);
    bus.NODE_RX_ADDR = a;
    bus.NODE_RX_DATA = d;
    bus.NODE_RX_PEND = p;
    bus.NODE_RX_REQ  = 1'b1;
    step(2);
    chk("fwd_req_early", bus.RX_REQ, 0);
    step(1);
    chk("fwd_req", bus.RX_REQ, 1);
    chk("fwd_addr", bus.RX_ADDR, a);
    chk("fwd_data", bus.RX_DATA, d);
    chk("fwd_pend", bus.RX_PEND, p);
    chk("fwd_nack", bus.NODE_RX_ACK, 0);
    bus.RX_ACK = 1'b1;
    step(1);
    chk("fwd_req_drop", bus.RX_REQ, 0);
    chk("fwd_ack", bus.NODE_RX_ACK, 1);
    bus.RX_ACK      = 1'b0;
    bus.NODE_RX_REQ = 1'b0;
    step(2);
    chk("fwd_ack_hold", bus.NODE_RX_ACK, 1);
    step(1);
    chk("fwd_ack_rel", bus.NODE_RX_ACK, 0);
    chk("fwd_fifo_empty", bus.CTRL_EMPTY, 1);
  endtask

  task automatic pop_chk(input logic [31:0] d);
    chk("pop_nonempty", bus.CTRL_EMPTY, 0);
    chk("pop_data", bus.CTRL_DATA, d);
    bus.CTRL_RD_EN = 1'b1;
    step(1);
    bus.CTRL_RD_EN = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    vecs[0] = '{addr: 8'h01, data: 32'hDEADBEEF, pend: 1'b0, is_ctrl: 1'b1, idx: 2'd0};
    vecs[1] = '{addr: 8'haa, data: 32'h12345678, pend: 1'b1, is_ctrl: 1'b0, idx: 2'd0};
    vecs[2] = '{addr: 8'h00, data: 32'h000000A5, pend: 1'b0, is_ctrl: 1'b1, idx: 2'd1};
    vecs[3] = '{addr: 8'hff, data: 32'hCAFEF00D, pend: 1'b0, is_ctrl: 1'b0, idx: 2'd0};
    vecs[4] = '{addr: 8'h02, data: 32'h00000005, pend: 1'b1, is_ctrl: 1'b0, idx: 2'd0};

    bus.NODE_RX_ADDR = '0; bus.NODE_RX_DATA = '0; bus.NODE_RX_PEND = 1'b0;
    bus.NODE_RX_REQ  = 1'b0; bus.RX_ACK = 1'b0; bus.CTRL_RD_EN = 1'b0;
    bus2.NODE_RX_ADDR = '0; bus2.NODE_RX_DATA = '0; bus2.NODE_RX_PEND = 1'b0;
    bus2.NODE_RX_REQ  = 1'b0; bus2.RX_ACK = 1'b0; bus2.CTRL_RD_EN = 1'b0;
    rst = 1'b1;
    step(3);
    chk("rst_node_ack", bus.NODE_RX_ACK, 0);
    chk("rst_rx_req", bus.RX_REQ, 0);
    chk("rst_rx_addr", bus.RX_ADDR, 0);
    chk("rst_rx_data", bus.RX_DATA, 0);
    chk("rst_rx_pend", bus.RX_PEND, 0);
    chk("rst_empty", bus.CTRL_EMPTY, 1);
    chk("rst_full", bus.CTRL_FULL, 0);
    chk("rst_ctrl_data", bus.CTRL_DATA, 0);
    chk("rst_ctrl_idx", bus.CTRL_IDX, 0);
    chk("rst_drop_cnt", bus.CTRL_DROP_CNT, 0);
    rst = 1'b0;
    step(1);

    // Vector table: one message each, control entries popped afterwards.
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].is_ctrl) begin
        ctrl_send(vecs[v].addr, vecs[v].data);
        chk("vec_ctrl_data", bus.CTRL_DATA, vecs[v].data);
        chk("vec_ctrl_idx", bus.CTRL_IDX, vecs[v].idx);
        bus.CTRL_RD_EN = 1'b1;
        step(1);
        bus.CTRL_RD_EN = 1'b0;
        chk("vec_ctrl_popped", bus.CTRL_EMPTY, 1);
      end else begin
        fwd_send(vecs[v].addr, vecs[v].data, vecs[v].pend);
      end
    end

    // Pop on an empty FIFO is ignored.
    bus.CTRL_RD_EN = 1'b1;
    step(1);
    bus.CTRL_RD_EN = 1'b0;
    chk("empty_pop_empty", bus.CTRL_EMPTY, 1);
    chk("empty_pop_full", bus.CTRL_FULL, 0);

    // Priority: 8'h12 matches both pairs, pair 0 wins.
    bus2.NODE_RX_ADDR = 8'h12;
    bus2.NODE_RX_DATA = 32'h00000055;
    bus2.NODE_RX_REQ  = 1'b1;
    step(4);
    chk("prio_ack", bus2.NODE_RX_ACK, 1);
    chk("prio_idx", bus2.CTRL_IDX, 0);
    chk("prio_data", bus2.CTRL_DATA, 32'h55);
    bus2.NODE_RX_REQ = 1'b0;
    step(3);

    // Fill the FIFO with messages 1..4, then offer a 5th.
    for (int k = 1; k <= 4; k++) ctrl_send(8'h01, 32'(k));
    chk("full_flag", bus.CTRL_FULL, 1);
    bus.NODE_RX_ADDR = 8'h01;
    bus.NODE_RX_DATA = 32'd5;
    bus.NODE_RX_REQ  = 1'b1;
`ifdef ULPB_RX_DISPATCH_DROP_EN
    step(4);
    chk("drop_ack", bus.NODE_RX_ACK, 1);
    chk("drop_cnt1", bus.CTRL_DROP_CNT, 1);
    chk("drop_still_full", bus.CTRL_FULL, 1);
    bus.NODE_RX_REQ = 1'b0;
    step(3);
    chk("drop_ack_rel", bus.NODE_RX_ACK, 0);
    for (int k = 0; k < 300; k++) begin
      bus.NODE_RX_REQ = 1'b1;
      step(4);
      bus.NODE_RX_REQ = 1'b0;
      step(3);
    end
    chk("drop_cnt_sat", bus.CTRL_DROP_CNT, 255);
    for (int k = 1; k <= 4; k++) pop_chk(32'(k));
`else
    step(8);
    chk("stall_nack", bus.NODE_RX_ACK, 0);
    chk("stall_head", bus.CTRL_DATA, 1);
    bus.CTRL_RD_EN = 1'b1;
    step(1);
    bus.CTRL_RD_EN = 1'b0;
    chk("stall_nack_pop_cyc", bus.NODE_RX_ACK, 0);
    step(1);
    chk("stall_ack_after_pop", bus.NODE_RX_ACK, 1);
    chk("stall_full_again", bus.CTRL_FULL, 1);
    bus.NODE_RX_REQ = 1'b0;
    step(3);
    chk("stall_ack_rel", bus.NODE_RX_ACK, 0);
    for (int k = 2; k <= 5; k++) pop_chk(32'(k));
`endif
    chk("drain_empty", bus.CTRL_EMPTY, 1);

    // Reset in the middle of a forwarded transaction.
    ctrl_send(8'h01, 32'h77);
    bus.NODE_RX_ADDR = 8'haa;
    bus.NODE_RX_DATA = 32'h0BADF00D;
    bus.NODE_RX_PEND = 1'b0;
    bus.NODE_RX_REQ  = 1'b1;
    step(3);
    chk("mid_rx_req", bus.RX_REQ, 1);
    rst = 1'b1;
    step(1);
    chk("rst_mid_rx_req", bus.RX_REQ, 0);
    chk("rst_mid_ack", bus.NODE_RX_ACK, 0);
    chk("rst_mid_empty", bus.CTRL_EMPTY, 1);
    chk("rst_mid_rx_data", bus.RX_DATA, 0);
    rst = 1'b0;
    step(2);
    chk("post_rst_req_early", bus.RX_REQ, 0);
    step(1);
    chk("post_rst_req", bus.RX_REQ, 1);
    chk("post_rst_data", bus.RX_DATA, 32'h0BADF00D);
    bus.RX_ACK = 1'b1;
    step(1);
    chk("post_rst_ack", bus.NODE_RX_ACK, 1);
    bus.RX_ACK      = 1'b0;
    bus.NODE_RX_REQ = 1'b0;
    step(3);
    chk("post_rst_ack_rel", bus.NODE_RX_ACK, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ulpb_rx_dispatch.md
Name: ulpb_rx_dispatch

Overview:
Parametrised receive dispatcher between a ulpb node's RX handshake and the local layer. Each received message is classified against up to NUM_CTRL_ADDR address/mask pairs. Matching messages are auto-acknowledged and buffered in an internal control FIFO for the bus controller's logic. All other messages pass to the layer through a full four-phase REQ/ACK handshake.

Parameters:
ADDR_WIDTH, 8, width of bus address
DATA_WIDTH, 32, width of message data word
NUM_CTRL_ADDR, 2, number of control address/mask pairs (1..4)
CTRL_ADDRESS, {8'h01,8'h00}, concatenated control addresses; index 0 in LSBs
CTRL_ADDR_MASK, {8'hff,8'hff}, concatenated masks; bit=1 means compared
FIFO_DEPTH, 4, control FIFO entries; power of two, 2..16

Ports:
CLK_EXT  in  1  single clock
RESET  in  1  synchronous, active-high reset
NODE_RX_ADDR  in  ADDR_WIDTH  node RX address, stable while NODE_RX_REQ high
NODE_RX_DATA  in  DATA_WIDTH  node RX data, stable while NODE_RX_REQ high
NODE_RX_PEND  in  1  node "more data follows" flag
NODE_RX_REQ  in  1  node request (asynchronous to CLK_EXT)
NODE_RX_ACK  out  1  acknowledge to node
RX_ADDR  out  ADDR_WIDTH  layer address, registered
RX_DATA  out  DATA_WIDTH  layer data, registered
RX_PEND  out  1  layer pend flag, registered
RX_REQ  out  1  layer request
RX_ACK  in  1  layer acknowledge
CTRL_RD_EN  in  1  pop control FIFO head
CTRL_EMPTY  out  1  control FIFO empty
CTRL_FULL  out  1  control FIFO full
CTRL_DATA  out  DATA_WIDTH  FIFO head data (first-word fall-through)
CTRL_IDX  out  2  index of the matching address pair for the head entry
CTRL_DROP_CNT  out  8  saturating count of dropped control messages

Behaviour:
- Reset values: NODE_RX_ACK=0, RX_REQ=0, RX_ADDR/RX_DATA/RX_PEND=0, CTRL_EMPTY=1, CTRL_FULL=0, CTRL_DATA/CTRL_IDX=0, CTRL_DROP_CNT=0. FIFO is flushed; FSM goes to IDLE.
- Reset mid-transaction aborts immediately, with no completion of an outstanding handshake. After reset, a NODE_RX_REQ that is still high is treated as a new request.
- Synchronisation: NODE_RX_REQ passes through a 2-flop synchroniser (req_s). NODE_RX_ADDR, NODE_RX_DATA and NODE_RX_PEND are sampled only when req_s=1.
- Match: pair i matches when ((NODE_RX_ADDR ^ addr_i) & mask_i)==0. If several pairs match, the lowest index wins.
- FSM states: IDLE, CAP, FWD_REQ, FWD_DONE, ACK_WAIT.
- IDLE, req_s=1, match: go to CAP.
- IDLE, req_s=1, no match: register ADDR/DATA/PEND onto RX_*, set RX_REQ=1, go to FWD_REQ.
- CAP, FIFO not full: push {idx,data}, set NODE_RX_ACK=1, go to ACK_WAIT.
- CAP, FIFO full: stay in CAP with ACK held low (see Optional Feature).
- FWD_REQ: wait for RX_ACK=1, then set RX_REQ=0 and NODE_RX_ACK=1, go to FWD_DONE.
- FWD_DONE: when req_s=0 and RX_ACK=0, set NODE_RX_ACK=0, go to IDLE.
- ACK_WAIT: when req_s=0, set NODE_RX_ACK=0, go to IDLE.
- Latency: NODE_RX_REQ rise to RX_REQ rise is 3 CLK_EXT cycles. NODE_RX_REQ rise to NODE_RX_ACK rise on the control path is 4 cycles.
- FIFO: pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- FIFO pop: CTRL_RD_EN with CTRL_EMPTY=1 is ignored.
- FIFO simultaneous push and pop: allowed; occupancy is unchanged.
- FIFO full: a push is blocked even if a pop occurs in the same cycle; the push succeeds on the following cycle.
- CTRL_DATA and CTRL_IDX update in the cycle after a push into an empty FIFO.

Optional Feature:
Macro ULPB_RX_DISPATCH_DROP_EN.
- Defined: CAP with FIFO full discards the message, sets NODE_RX_ACK=1 and goes to ACK_WAIT. CTRL_DROP_CNT increments and saturates at 255.
- Undefined: CAP stalls until space is available. CTRL_DROP_CNT is tied to 0.

Decomposition:
- Shared ulpb package: ADDR_WIDTH and DATA_WIDTH defaults, FSM state encoding constants, and the FIFO entry layout {idx[1:0], data}.
- One sub-module: ulpb_sync_fifo (parametrised width/depth, first-word fall-through, full/empty flags), instantiated for the control FIFO.

Test Plan:
1. Control capture: NODE_RX_ADDR=8'h01, DATA=32'hDEADBEEF, REQ raised.
   -> NODE_RX_ACK=1 after 4 cycles; RX_REQ stays 0; CTRL_EMPTY=0, CTRL_DATA=32'hDEADBEEF, CTRL_IDX=0.
   -> After REQ drops, ACK=0 within 3 cycles.
2. Forwarding: ADDR=8'haa, DATA=32'h12345678.
   -> RX_REQ=1 after 3 cycles with RX_DATA=32'h12345678.
   -> Layer ACK gives NODE_RX_ACK=1 and RX_REQ=0.
   -> Full four-phase handshake completes back to IDLE.
3. Priority: pairs {8'h10 mask 8'hf0, 8'h12 mask 8'hff}, ADDR=8'h12 -> CTRL_IDX=0.
4. Full stall (macro off): push 4 control messages with no reads, then send a 5th.
   -> NODE_RX_ACK stays 0; after one CTRL_RD_EN it is acked on the following cycle.
   -> Pop order is 1..5.
5. Drop (macro on): same stimulus as scenario 4.
   -> 5th message is acked and discarded, CTRL_DROP_CNT=1, FIFO contents 1..4.
   -> After 300 further drops, CTRL_DROP_CNT=255.
6. Reset mid-FWD_REQ: assert RESET for 1 cycle.
   -> RX_REQ=0, NODE_RX_ACK=0, FIFO empty.
   -> NODE_RX_REQ still high produces a new RX_REQ 3 cycles after reset release.
